aes_round_key_sequencer: RTL and testbench

Sits directly downstream of AES_key_memory and owns its `times`/`key` inputs. Accepts a 128-bit cipher key over a valid/ready handshake and steps the key memory through rounds 0..NR, one round per clock. Captures every round key into a local buffer. Then streams round keys to the round datapath over a valid/ready interface, in encrypt order (0→NR) or decrypt order (NR→0).

---
 rtl/aes_round_key_sequencer.sv | 158 +++++++++++++++
 tb/tb_aes_round_key_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_sequencer.sv
// Steps AES_key_memory through rounds 0..NR, buffers every round key and streams them
// in encrypt or decrypt order. Optional macro KEY_CACHE_EN skips re-expanding the last key.
module aes_round_key_sequencer #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [3:0]    km_times,
  output logic [KW-1:0] km_key,
  input  logic [KW-1:0] km_keyout,
  output logic          expanded,
  input  logic          strm_start,
  input  logic          strm_dec,
  output logic [KW-1:0] rk_data,
  output logic [3:0]    rk_round,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic          rk_last,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;
  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]    r_state;
  logic [3:0]    r_k;
  logic [3:0]    r_idx;
  logic          r_dec;
  logic          r_expanded;
  logic [KW-1:0] r_km_key;
  logic [KW-1:0] r_rk_data;
  logic [3:0]    r_rk_round;
  logic          r_rk_valid;
  logic          r_rk_last;
  logic [KW-1:0] r_buf [0:NR];

  logic          w_accept;
  logic          w_hit;
  logic          w_start;
  logic [3:0]    w_first;
  logic [3:0]    w_next;
  logic [3:0]    w_end;

  assign w_accept = key_valid && ((r_state == S_IDLE) || (r_state == S_READY));
  assign w_start  = (r_state == S_READY) && strm_start && !key_valid;
  assign w_first  = strm_dec ? LAST_RND : 4'd0;
  assign w_next   = r_dec ? (r_idx - 4'd1) : (r_idx + 4'd1);
  assign w_end    = r_dec ? 4'd0 : LAST_RND;

`ifdef KEY_CACHE_EN
  logic [KW-1:0] r_tag;
  logic          r_tag_valid;

  assign w_hit = w_accept && (r_state == S_READY) && r_tag_valid && (key_in == r_tag);

  // Tag tracks the last key whose schedule completed; any new expansion invalidates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else if ((r_state == S_EXPAND) && (r_k == LAST_RND)) begin
      r_tag       <= r_km_key;
      r_tag_valid <= 1'b1;
    end else if (w_accept && !w_hit) begin
      r_tag_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) r_buf[i] <= '0;
    end else if (r_state == S_EXPAND) begin
      r_buf[r_k] <= km_keyout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 4'd0;
      r_idx      <= 4'd0;
      r_dec      <= 1'b0;
      r_expanded <= 1'b0;
      r_km_key   <= '0;
      r_rk_data  <= '0;
      r_rk_round <= 4'd0;
      r_rk_valid <= 1'b0;
      r_rk_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (w_accept) begin
            r_km_key <= key_in;
            r_k      <= 4'd0;
            if (!w_hit) begin
              r_expanded <= 1'b0;
              r_state    <= S_EXPAND;
            end
          end else if (w_start) begin
            r_dec      <= strm_dec;
            r_idx      <= w_first;
            r_rk_data  <= r_buf[w_first];
            r_rk_round <= w_first;
            r_rk_valid <= 1'b1;
            r_rk_last  <= (LAST_RND == 4'd0);
            r_state    <= S_STREAM;
          end
        end
        S_EXPAND: begin
          // km_times is the live counter, so it must drop back to 0 on completion.
          if (r_k == LAST_RND) begin
            r_k        <= 4'd0;
            r_expanded <= 1'b1;
            r_state    <= S_READY;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        S_STREAM: begin
          if (rk_ready) begin
            if (r_rk_last) begin
              r_rk_valid <= 1'b0;
              r_rk_last  <= 1'b0;
              r_state    <= S_READY;
            end else begin
              r_idx      <= w_next;
              r_rk_data  <= r_buf[w_next];
              r_rk_round <= w_next;
              r_rk_last  <= (w_next == w_end);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = (r_state == S_IDLE) || (r_state == S_READY);
  assign busy      = (r_state == S_EXPAND) || (r_state == S_STREAM);
  assign km_times  = r_k;
  assign km_key    = r_km_key;
  assign expanded  = r_expanded;
  assign rk_data   = r_rk_data;
  assign rk_round  = r_rk_round;
  assign rk_valid  = r_rk_valid;
  assign rk_last   = r_rk_last;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Directed bench for aes_round_key_sequencer with an AES-128 key-memory model and a
// scoreboard of expected round-key beats.
module tb_aes_round_key_sequencer;

  typedef struct packed {
    logic         last;
    logic [3:0]   rnd;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   km_times;
  logic [127:0] km_key;
  logic [127:0] km_keyout;
  logic         expanded;
  logic         strm_start;
  logic         strm_dec;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  beat_t q[$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // AES-128 key schedule: round key rnd derived from the cipher key.
  function automatic logic [127:0] aes_rk(input logic [127:0] key, input int rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int i = 0; i < rnd; i++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end
    return {w0, w1, w2, w3};
  endfunction

  always_comb km_keyout = aes_rk(km_key, int'(km_times));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  aes_round_key_sequencer dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .km_times(km_times), .km_key(km_key), .km_keyout(km_keyout), .expanded(expanded),
    .strm_start(strm_start), .strm_dec(strm_dec), .rk_data(rk_data), .rk_round(rk_round),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input logic with_start);
    key_in     = k;
    key_valid  = 1'b1;
    strm_start = with_start;
    strm_dec   = 1'b0;
    step();
    key_valid  = 1'b0;
    strm_start = 1'b0;
  endtask

  // Counts cycles from the accept edge until expanded rises, checking km_times on the way.
  task automatic expand_wait(output int cycles);
    cycles = 0;
    while (!expanded && cycles < 40) begin
      chk("km_times_step", {124'd0, km_times}, 128'(cycles));
      chk("busy_expand", {127'd0, busy}, 128'd1);
      chk("rk_valid_expand", {127'd0, rk_valid}, 128'd0);
      step();
      cycles++;
    end
    chk("km_times_idle", {124'd0, km_times}, 128'd0);
  endtask

  // Streams the schedule of key k; stalls stall_cyc cycles on stall_rnd.
  task automatic stream(input logic [127:0] k, input logic dec, input int stall_rnd,
                        input int stall_cyc, output logic [127:0] first_d,
                        output logic [127:0] last_d);
    int    guard;
    int    stalled;
    beat_t b;
    for (int i = 0; i <= 10; i++) begin
      b.rnd  = dec ? 4'(10 - i) : 4'(i);
      b.data = aes_rk(k, int'(b.rnd));
      b.last = (i == 10);
      q.push_back(b);
    end
    strm_start = 1'b1;
    strm_dec   = dec;
    rk_ready   = 1'b1;
    step();
    strm_start = 1'b0;
    strm_dec   = 1'b0;
    guard      = 0;
    stalled    = 0;
    first_d    = '0;
    last_d     = '0;
    while (q.size() > 0 && guard < 100) begin
      chk("rk_valid_stream", {127'd0, rk_valid}, 128'd1);
      chk("key_ready_stream", {127'd0, key_ready}, 128'd0);
      chk("rk_round", {124'd0, rk_round}, {124'd0, q[0].rnd});
      chk("rk_data", rk_data, q[0].data);
      if (int'(q[0].rnd) == stall_rnd && stalled < stall_cyc) begin
        rk_ready = 1'b0;
        stalled++;
      end else begin
        rk_ready = 1'b1;
        chk("rk_last", {127'd0, rk_last}, {127'd0, q[0].last});
        if (q.size() == 11) first_d = rk_data;
        last_d = rk_data;
        void'(q.pop_front());
      end
      step();
      guard++;
    end
    chk("stream_drained", 128'(q.size()), 128'd0);
    q.delete();
    rk_ready = 1'b0;
    chk("rk_valid_after", {127'd0, rk_valid}, 128'd0);
    chk("rk_last_after", {127'd0, rk_last}, 128'd0);
    chk("expanded_after", {127'd0, expanded}, 128'd1);
    chk("key_ready_after", {127'd0, key_ready}, 128'd1);
    chk("busy_after", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int           cyc;
    logic [127:0] fd;
    logic [127:0] ld;
    rst        = 1'b1;
    key_in     = '0;
    key_valid  = 1'b0;
    strm_start = 1'b0;
    strm_dec   = 1'b0;
    rk_ready   = 1'b0;
    #12;
    chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_expanded", {127'd0, expanded}, 128'd0);
    chk("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_rk_last", {127'd0, rk_last}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_km_times", {124'd0, km_times}, 128'd0);
    chk("rst_km_key", km_key, 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    chk("rst_rk_round", {124'd0, rk_round}, 128'd0);
    #5;
    rst = 1'b0;
    step();

    // Encrypt order, full-rate consumer.
    load_key(K1, 1'b0);
    chk("km_key_reg", km_key, K1);
    expand_wait(cyc);
    chk("expand_cycles", 128'(cyc), 128'd11);
    stream(K1, 1'b0, -1, 0, fd, ld);
    chk("enc_round0_is_key", fd, K1);
    chk("enc_round10_fips", ld, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Decrypt order from the same schedule.
    stream(K1, 1'b1, -1, 0, fd, ld);
    chk("dec_first_round10", fd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("dec_last_round0", ld, K1);

    // Backpressure on round 4.
    stream(K1, 1'b0, 4, 3, fd, ld);

    // Key load and stream start together: the load wins.
    load_key(K2, 1'b1);
    chk("collide_rk_valid", {127'd0, rk_valid}, 128'd0);
    chk("collide_expanded", {127'd0, expanded}, 128'd0);
    expand_wait(cyc);
    chk("collide_cycles", 128'(cyc), 128'd11);
    stream(K2, 1'b0, -1, 0, fd, ld);

    // Reload of the identical key.
    load_key(K2, 1'b0);
`ifdef KEY_CACHE_EN
    chk("hit_expanded", {127'd0, expanded}, 128'd1);
    chk("hit_km_times", {124'd0, km_times}, 128'd0);
    chk("hit_busy", {127'd0, busy}, 128'd0);
`else
    expand_wait(cyc);
    chk("same_key_cycles", 128'(cyc), 128'd11);
`endif
    load_key(K1, 1'b0);
    expand_wait(cyc);
    chk("new_key_cycles", 128'(cyc), 128'd11);
    stream(K1, 1'b1, 7, 2, fd, ld);

    // Reset during the 5th EXPAND cycle.
    load_key(K2, 1'b0);
    repeat (4) step();
    chk("pre_rst_km_times", {124'd0, km_times}, 128'd4);
    rst = 1'b1;
    #1;
    chk("abort_key_ready", {127'd0, key_ready}, 128'd1);
    chk("abort_expanded", {127'd0, expanded}, 128'd0);
    chk("abort_km_times", {124'd0, km_times}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_buf0", dut.r_buf[0], 128'd0);
    chk("abort_buf3", dut.r_buf[3], 128'd0);
    chk("abort_buf10", dut.r_buf[10], 128'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_expanded", {127'd0, expanded}, 128'd0);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
